// File: rtl/mario_motion_if.sv
// Player motion bus: button/strobe inputs toward the motion block and the
// kinematic outputs it produces for the sprite-select and render stages.
interface mario_motion_if;
  logic        tick;
  logic        left;
  logic        right;
  logic        jump_btn;
  logic        level;
  logic [10:0] x;
  logic [10:0] y;
  logic        airborne;
  logic        walking;
  logic        landed;
  logic [1:0]  mstate;

  modport master (
    output tick, left, right, jump_btn, level,
    input  x, y, airborne, walking, landed, mstate
  );

  modport slave (
    input  tick, left, right, jump_btn, level,
    output x, y, airborne, walking, landed, mstate
  );
endinterface

// File: rtl/mario_motion.sv
// Per-frame player kinematics: buttons in, sprite position and jump/fall state out.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  GROUND | standing on GROUND_Y, a latched jump request launches a jump
//  RISE   | moving up, speed decays by GRAVITY, release cuts speed to CUT_V
//  FALL   | moving down, speed grows to MAX_FALL, clamps and lands on GROUND_Y
module mario_motion #(
  parameter logic [11:0] X_RESET   = 12'd40,
  parameter logic [11:0] X_MIN     = 12'd0,
  parameter logic [11:0] X_MAX     = 12'd600,
  parameter logic [11:0] GROUND_Y  = 12'd400,
  parameter logic [11:0] WALK_STEP = 12'd2,
  parameter logic [4:0]  JUMP_V    = 5'd12,
  parameter logic [4:0]  GRAVITY   = 5'd1,
  parameter logic [4:0]  MAX_FALL  = 5'd12,
  parameter logic [4:0]  CUT_V     = 5'd3
) (
  input  logic           clk,
  input  logic           rstn,
  mario_motion_if.slave  bus
);

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    RISE   = 2'b01,
    FALL   = 2'b10
  } state_t;

  state_t      state_q, state_nxt;
  logic [10:0] x_q, x_nxt;
  logic [10:0] y_q, y_nxt;
  logic [4:0]  vy_q, vy_nxt;
  logic        jump_req_q, jump_req_nxt;
  logic        jump_prev_q;
  logic        airborne_q, airborne_nxt;
  logic        walking_q;
  logic        landed_q, landed_nxt;

  logic [11:0] lim;
  logic [11:0] x_ext;
  logic [11:0] y_ext;
  logic [4:0]  vc;
  logic [4:0]  nv;

  // State and datapath registers; everything visible downstream is a flop.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= GROUND;
      x_q         <= X_RESET[10:0];
      y_q         <= GROUND_Y[10:0];
      vy_q        <= 5'd0;
      jump_req_q  <= 1'b0;
      jump_prev_q <= 1'b0;
      airborne_q  <= 1'b0;
      walking_q   <= 1'b0;
      landed_q    <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      x_q         <= x_nxt;
      y_q         <= y_nxt;
      vy_q        <= vy_nxt;
      jump_req_q  <= jump_req_nxt;
      jump_prev_q <= bus.jump_btn;
      airborne_q  <= airborne_nxt;
      walking_q   <= bus.left ^ bus.right;
      landed_q    <= landed_nxt;
    end
  end

  // Next state plus horizontal/vertical motion; nothing moves without a tick.
  always_comb begin
    lim          = X_MAX - (bus.level ? 12'd45 : 12'd40);
    x_ext        = {1'b0, x_q};
    y_ext        = {1'b0, y_q};
    vc           = vy_q;
    nv           = vy_q;
    state_nxt    = state_q;
    x_nxt        = x_q;
    y_nxt        = y_q;
    vy_nxt       = vy_q;

    if (bus.tick) begin
      // An edge that shrank (big sprite) pulls x back inside before buttons count.
      if (x_ext > lim)
        x_nxt = lim[10:0];
      else if (bus.left && !bus.right)
        x_nxt = (x_ext < X_MIN + WALK_STEP) ? X_MIN[10:0] : 11'(x_ext - WALK_STEP);
      else if (bus.right && !bus.left)
        x_nxt = (x_ext + WALK_STEP > lim) ? lim[10:0] : 11'(x_ext + WALK_STEP);

      case (state_q)
        GROUND: begin
          if (jump_req_q) begin
            vy_nxt    = JUMP_V;
            state_nxt = RISE;
          end
        end
        RISE: begin
          if (!bus.jump_btn && vy_q > CUT_V)
            vc = CUT_V;
          y_nxt  = (y_ext < {7'd0, vc}) ? 11'd0 : 11'(y_ext - {7'd0, vc});
          vy_nxt = vc - GRAVITY;
          if (vy_nxt == 5'd0)
            state_nxt = FALL;
        end
        FALL: begin
          nv = (vy_q + GRAVITY > MAX_FALL) ? MAX_FALL : vy_q + GRAVITY;
          if (y_ext + {7'd0, nv} >= GROUND_Y) begin
            y_nxt     = GROUND_Y[10:0];
            vy_nxt    = 5'd0;
            state_nxt = GROUND;
          end else begin
            y_nxt  = 11'(y_ext + {7'd0, nv});
            vy_nxt = nv;
          end
        end
        default: begin
          state_nxt = GROUND;
          vy_nxt    = 5'd0;
        end
      endcase
    end

    // Requests never survive airborne clks, so a press in the air cannot buffer a jump.
    if (state_q != GROUND)
      jump_req_nxt = 1'b0;
    else if (bus.jump_btn && !jump_prev_q)
      jump_req_nxt = 1'b1;
    else if (bus.tick && jump_req_q)
      jump_req_nxt = 1'b0;
    else
      jump_req_nxt = jump_req_q;
  end

  // Status outputs derived from the transition being taken this clk.
  always_comb begin
    airborne_nxt = (state_nxt != GROUND);
    landed_nxt   = bus.tick && (state_q == FALL) && (state_nxt == GROUND);
  end

  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.airborne = airborne_q;
  assign bus.walking  = walking_q;
  assign bus.landed   = landed_q;
  assign bus.mstate   = state_q;

endmodule

// File: tb/tb_mario_motion.sv
// Bench for mario_motion: directed scenarios plus random buttons against a behavioural model.
module tb_mario_motion;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int   total = 0;
  int   bad = 0;

  mario_motion_if bus();

  mario_motion dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: ph 0 = ground, 1 = rising, 2 = falling.
  int m_x, m_y, m_vy, m_ph;
  bit m_req, m_prev, m_walk, m_air, m_landed;

  task automatic model_clk();
    int lim, nx, ny, nvy, nph, v;
    bit consumed, edge_seen;
    if (rstn) begin
      m_x = 40; m_y = 400; m_vy = 0; m_ph = 0; m_req = 0; m_prev = 0;
      m_air = 0; m_walk = 0; m_landed = 0;
      return;
    end
    consumed = 0;
    edge_seen = bus.jump_btn && !m_prev;
    nx = m_x; ny = m_y; nvy = m_vy; nph = m_ph; m_landed = 0;
    if (bus.tick) begin
      lim = 600 - (bus.level ? 45 : 40);
      if (m_x > lim) nx = lim;
      else if (bus.left && !bus.right) nx = (m_x - 2 < 0) ? 0 : m_x - 2;
      else if (bus.right && !bus.left) nx = (m_x + 2 > lim) ? lim : m_x + 2;
      if (m_ph == 0) begin
        if (m_req) begin nvy = 12; nph = 1; consumed = 1; end
      end else if (m_ph == 1) begin
        v = m_vy;
        if (!bus.jump_btn && v > 3) v = 3;
        ny = (m_y - v < 0) ? 0 : m_y - v;
        nvy = v - 1;
        if (nvy == 0) nph = 2;
      end else begin
        v = (m_vy + 1 > 12) ? 12 : m_vy + 1;
        if (m_y + v >= 400) begin ny = 400; nvy = 0; nph = 0; m_landed = 1; end
        else begin ny = m_y + v; nvy = v; end
      end
    end
    if (m_ph != 0) m_req = 0;
    else if (edge_seen) m_req = 1;
    else if (consumed) m_req = 0;
    m_x = nx; m_y = ny; m_vy = nvy; m_ph = nph;
    m_prev = bus.jump_btn;
    m_walk = bus.left ^ bus.right;
    m_air = (nph != 0);
  endtask

  function automatic logic [26:0] model_vec();
    return {11'(m_x), 11'(m_y), m_air, m_walk, m_landed, 2'(m_ph)};
  endfunction

  function automatic logic [26:0] dut_vec();
    return {bus.x, bus.y, bus.airborne, bus.walking, bus.landed, bus.mstate};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic tick_clk();
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
  endtask

  task automatic tick_once();
    tick_clk();
    cyc();
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    bus.right = 1'b1;
    bus.jump_btn = 1'b1;
    bus.tick = 1'b1;
    repeat (3) cyc();
    total++;
    if (dut_vec() !== {11'd40, 11'd400, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      bad++; $display("FAIL reset_outputs actual=%h expected=%h", dut_vec(),
                      {11'd40, 11'd400, 1'b0, 1'b0, 1'b0, 2'b00});
    end
    bus.right = 1'b0; bus.jump_btn = 1'b0; bus.tick = 1'b0;
    rstn = 1'b0;
    cyc();
  endtask

  task automatic test_walk();
    bus.right = 1'b1;
    repeat (10) tick_once();
    total++;
    if (bus.x !== 11'd60) begin bad++; $display("FAIL walk_x actual=%0d expected=60", bus.x); end
    total++;
    if (bus.walking !== 1'b1 || bus.airborne !== 1'b0 || bus.y !== 11'd400) begin
      bad++; $display("FAIL walk_flags walking=%b airborne=%b y=%0d expected 1 0 400",
                      bus.walking, bus.airborne, bus.y);
    end
    total++;
    if (dut_vec() !== model_vec()) begin
      bad++; $display("FAIL walk_model actual=%h expected=%h", dut_vec(), model_vec());
    end
    bus.right = 1'b0;
    cyc();
    total++;
    if (bus.walking !== 1'b0) begin bad++; $display("FAIL walk_release actual=%b expected=0", bus.walking); end
  endtask

  task automatic test_full_jump();
    bus.jump_btn = 1'b1;
    tick_clk();
    total++;
    if (bus.mstate !== 2'b00) begin bad++; $display("FAIL jump_press_tick mstate actual=%b expected=00", bus.mstate); end
    cyc();
    tick_once();
    total++;
    if (bus.mstate !== 2'b01 || bus.y !== 11'd400) begin
      bad++; $display("FAIL jump_launch mstate=%b y=%0d expected 01 400", bus.mstate, bus.y);
    end
    tick_once();
    total++;
    if (bus.y !== 11'd388) begin bad++; $display("FAIL jump_first_rise y actual=%0d expected=388", bus.y); end
    repeat (11) tick_once();
    total++;
    if (bus.y !== 11'd322 || bus.mstate !== 2'b10) begin
      bad++; $display("FAIL jump_apex y=%0d mstate=%b expected 322 10", bus.y, bus.mstate);
    end
    repeat (11) tick_once();
    total++;
    if (bus.y !== 11'd388 || bus.mstate !== 2'b10 || bus.landed !== 1'b0) begin
      bad++; $display("FAIL jump_pre_land y=%0d mstate=%b landed=%b expected 388 10 0",
                      bus.y, bus.mstate, bus.landed);
    end
    tick_clk();
    total++;
    if (bus.y !== 11'd400 || bus.mstate !== 2'b00 || bus.landed !== 1'b1 || bus.airborne !== 1'b0) begin
      bad++; $display("FAIL jump_land y=%0d mstate=%b landed=%b airborne=%b expected 400 00 1 0",
                      bus.y, bus.mstate, bus.landed, bus.airborne);
    end
    cyc();
    total++;
    if (bus.landed !== 1'b0) begin bad++; $display("FAIL jump_land_pulse actual=%b expected=0", bus.landed); end
    bus.jump_btn = 1'b0;
    cyc();
  endtask

  task automatic test_short_jump();
    int lands;
    bus.jump_btn = 1'b1;
    cyc();
    tick_once();
    tick_once();
    tick_once();
    total++;
    if (bus.y !== 11'd377) begin bad++; $display("FAIL short_rise y actual=%0d expected=377", bus.y); end
    bus.jump_btn = 1'b0;
    tick_once();
    total++;
    if (bus.y !== 11'd374) begin bad++; $display("FAIL short_cut1 y actual=%0d expected=374", bus.y); end
    tick_once();
    total++;
    if (bus.y !== 11'd372) begin bad++; $display("FAIL short_cut2 y actual=%0d expected=372", bus.y); end
    tick_once();
    total++;
    if (bus.y !== 11'd371 || bus.mstate !== 2'b10) begin
      bad++; $display("FAIL short_apex y=%0d mstate=%b expected 371 10", bus.y, bus.mstate);
    end
    lands = 0;
    for (int i = 0; i < 20; i++) begin
      tick_clk();
      if (bus.landed === 1'b1) lands++;
      cyc();
      if (bus.landed === 1'b1) lands++;
    end
    total++;
    if (lands != 1 || bus.y !== 11'd400 || bus.mstate !== 2'b00) begin
      bad++; $display("FAIL short_land pulses=%0d y=%0d mstate=%b expected 1 400 00", lands, bus.y, bus.mstate);
    end
  endtask

  task automatic test_clamp();
    bus.level = 1'b0;
    bus.right = 1'b1;
    repeat (260) tick_once();
    total++;
    if (bus.x !== 11'd560) begin bad++; $display("FAIL clamp_right x actual=%0d expected=560", bus.x); end
    tick_once();
    total++;
    if (bus.x !== 11'd560) begin bad++; $display("FAIL clamp_hold x actual=%0d expected=560", bus.x); end
    bus.level = 1'b1;
    tick_once();
    total++;
    if (bus.x !== 11'd555) begin bad++; $display("FAIL clamp_big x actual=%0d expected=555", bus.x); end
    bus.right = 1'b0;
    bus.left = 1'b1;
    repeat (277) tick_once();
    total++;
    if (bus.x !== 11'd1) begin bad++; $display("FAIL clamp_left1 x actual=%0d expected=1", bus.x); end
    tick_once();
    total++;
    if (bus.x !== 11'd0) begin bad++; $display("FAIL clamp_left0 x actual=%0d expected=0", bus.x); end
    tick_once();
    total++;
    if (bus.x !== 11'd0 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL clamp_nowrap actual=%h expected=%h", dut_vec(), model_vec());
    end
    bus.left = 1'b0;
    bus.level = 1'b0;
    cyc();
  endtask

  task automatic test_hold_landing();
    bit air;
    bus.jump_btn = 1'b1;
    air = 0;
    for (int i = 0; i < 60; i++) begin
      tick_once();
      if (bus.mstate !== 2'b00) air = 1;
      else if (air) break;
    end
    repeat (5) tick_once();
    total++;
    if (air !== 1'b1 || bus.mstate !== 2'b00 || bus.airborne !== 1'b0) begin
      bad++; $display("FAIL hold_no_rejump seen_air=%b mstate=%b airborne=%b expected 1 00 0",
                      air, bus.mstate, bus.airborne);
    end
    bus.jump_btn = 1'b0;
    cyc();
    bus.jump_btn = 1'b1;
    cyc();
    bus.jump_btn = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick_once();
      if (bus.mstate === 2'b10) break;
    end
    bus.jump_btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick_once();
      if (bus.mstate === 2'b00) break;
    end
    repeat (5) tick_once();
    total++;
    if (bus.mstate !== 2'b00 || dut_vec() !== model_vec()) begin
      bad++; $display("FAIL fall_press_ignored actual=%h expected=%h", dut_vec(), model_vec());
    end
    bus.jump_btn = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_rise();
    bus.jump_btn = 1'b1;
    cyc();
    tick_once();
    repeat (3) tick_once();
    bus.right = 1'b1;
    cyc();
    total++;
    if (bus.mstate !== 2'b01 || bus.walking !== 1'b1) begin
      bad++; $display("FAIL midrise_setup mstate=%b walking=%b expected 01 1", bus.mstate, bus.walking);
    end
    rstn = 1'b1;
    cyc();
    total++;
    if (dut_vec() !== {11'd40, 11'd400, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      bad++; $display("FAIL midrise_reset actual=%h expected=%h", dut_vec(),
                      {11'd40, 11'd400, 1'b0, 1'b0, 1'b0, 2'b00});
    end
    rstn = 1'b0;
    bus.right = 1'b0;
    bus.jump_btn = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    bus.tick = 1'b1;
    bus.jump_btn = 1'b1;
    cyc();
    total++;
    if (bus.mstate !== 2'b00) begin bad++; $display("FAIL b2b_latch mstate actual=%b expected=00", bus.mstate); end
    cyc();
    total++;
    if (bus.mstate !== 2'b01 || bus.y !== 11'd400) begin
      bad++; $display("FAIL b2b_launch mstate=%b y=%0d expected 01 400", bus.mstate, bus.y);
    end
    for (int i = 0; i < 30; i++) begin
      cyc();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL b2b_cycle%0d actual=%h expected=%h", i, dut_vec(), model_vec());
      end
    end
    bus.tick = 1'b0;
    bus.jump_btn = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bus.tick  = ($urandom_range(0, 2) == 0);
      bus.left  = ($urandom_range(0, 9) < 3);
      bus.right = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 5) == 0) bus.jump_btn = ~bus.jump_btn;
      if ($urandom_range(0, 199) == 0) bus.level = ~bus.level;
      rstn = ($urandom_range(0, 599) == 0);
      cyc();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL random_cycle%0d actual=%h expected=%h", i, dut_vec(), model_vec());
      end
    end
    rstn = 1'b0;
    bus.tick = 1'b0; bus.left = 1'b0; bus.right = 1'b0; bus.jump_btn = 1'b0; bus.level = 1'b0;
    cyc();
  endtask

  initial begin
    bus.tick = 1'b0; bus.left = 1'b0; bus.right = 1'b0; bus.jump_btn = 1'b0; bus.level = 1'b0;
    test_reset();
    test_walk();
    test_full_jump();
    test_short_jump();
    test_clamp();
    test_hold_landing();
    test_reset_mid_rise();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
